// File: rtl/uart_packetizer_pkg.sv
// Shared definitions for the UART packetizer: FSM encoding, default sync byte
// and the byte-counter width helper.
package uart_packetizer_pkg;

  // FSM state encoding
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StStart = 2'd2;
  localparam logic [1:0] StWait  = 2'd3;

  // Header byte sent ahead of every word
  localparam logic [7:0] SyncByteDefault = 8'hA5;

  // Bits needed to count the payload bytes of one word (at least 1)
  function automatic int unsigned byte_cnt_width(input int unsigned word_width);
    int unsigned num_bytes;
    num_bytes = word_width / 8;
    if (num_bytes <= 1) begin
      return 1;
    end
    return $clog2(num_bytes);
  endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous word FIFO with occupancy count. Full and empty derive from the
// level; pointers wrap naturally because DEPTH is a power of two.
module pkt_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LevelW = PtrW + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] level_q;
  logic              do_push, do_pop;

  assign full    = (level_q == LevelW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the level unchanged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        level_q <= level_q + 1'b1;
      end else if (do_pop && !do_push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_packetizer.sv
// Buffers correlator words and hands them to a byte serializer as frames:
// one sync byte followed by the word's bytes, least-significant first.
module uart_packetizer
  import uart_packetizer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = SyncByteDefault
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [WORD_WIDTH-1:0]         word_in,
  input  logic                          word_valid,
  output logic                          word_ready,
  output logic [7:0]                    tx_din,
  output logic                          tx_start,
  input  logic                          tx_done,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned NumBytes = WORD_WIDTH / 8;
  localparam int unsigned CntW     = byte_cnt_width(WORD_WIDTH);
  localparam logic [CntW-1:0] LastByte = CntW'(NumBytes - 1);

  logic [1:0]            state_q, state_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]       byte_cnt_q, byte_cnt_d;
  logic                  hdr_q, hdr_d;
  logic [7:0]            tx_din_q, tx_din_d;
  logic                  tx_start_q, tx_start_d;
  logic                  overflow_q, overflow_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WORD_WIDTH-1:0] fifo_dout;

  assign word_ready = !fifo_full;
  assign fifo_push  = word_valid && word_ready;
  assign overflow_d = overflow_q || (word_valid && !word_ready);

  pkt_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (word_in),
    .dout    (fifo_dout),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Frame sequencing; tx_start/tx_din are computed here and registered below
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    hdr_d      = hdr_q;
    tx_din_d   = tx_din_q;
    tx_start_d = 1'b0;
    fifo_pop   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_d    = fifo_dout;
          byte_cnt_d = '0;
          hdr_d      = 1'b1;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        tx_din_d   = hdr_q ? SYNC_BYTE : shift_q[7:0];
        // Registered so the pulse is high exactly while in StStart
        tx_start_d = 1'b1;
        state_d    = StStart;
      end
      StStart: begin
        state_d = StWait;
      end
      StWait: begin
        if (tx_done) begin
          if (hdr_q) begin
            hdr_d   = 1'b0;
            state_d = StLoad;
          end else begin
            shift_d    = shift_q >> 8;
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = (byte_cnt_q == LastByte) ? StIdle : StLoad;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered serializer outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      hdr_q      <= 1'b0;
      tx_din_q   <= 8'h00;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      hdr_q      <= hdr_d;
      tx_din_q   <= tx_din_d;
      tx_start_q <= tx_start_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_din   = tx_din_q;
  assign tx_start = tx_start_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != StIdle) || !fifo_empty;

endmodule
